// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
// One-stage registered bitwise ALU with a valid/ready handshake on each side
// and a saturating counter of accepted beats whose operands were equal.
//
// Ports:
//   CLK        - clock; all state changes on its rising edge
//   RSTn       - asynchronous active-low reset
//   IN_VALID   - operand beat valid
//   IN_READY   - block can take a beat: (not OUT_VALID) or OUT_READY
//   IN0, IN1   - operands A and B (WIDTH bits)
//   MODE       - operation select, sampled with the operands
//   OUT_VALID  - result register holds a beat
//   OUT_READY  - downstream takes the result
//   OUT0       - registered result (WIDTH bits)
//   EQ         - registered flag: the beat's IN0 equalled its IN1
//   CLR_CNT    - synchronous clear of MATCH_CNT, wins over increment
//   MATCH_CNT  - saturating count of accepted beats with IN0 == IN1
module bitwise_logic_pipe #(
    parameter int WIDTH     = 1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [WIDTH-1:0]     IN0,
    input  logic [WIDTH-1:0]     IN1,
    input  logic [2:0]           MODE,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [WIDTH-1:0]     OUT0,
    output logic                 EQ,
    input  logic                 CLR_CNT,
    output logic [CNT_WIDTH-1:0] MATCH_CNT
);

    logic             accept;
    logic             operands_equal;
    logic [WIDTH-1:0] result;

    // The output register is free when empty or being drained this cycle,
    // so a drain and a new acceptance can share one edge without a bubble.
    assign IN_READY       = !OUT_VALID || OUT_READY;
    assign accept         = IN_VALID && IN_READY;
    assign operands_equal = (IN0 == IN1);

    always_comb begin
        result = '0;
        unique case (MODE)
            3'd0:    result = ~(IN0 ^ IN1);
            3'd1:    result = IN0 ^ IN1;
            3'd2:    result = IN0 & IN1;
            3'd3:    result = IN0 | IN1;
            3'd4:    result = ~(IN0 & IN1);
            3'd5:    result = ~(IN0 | IN1);
            3'd6:    result = IN0;
            3'd7:    result = ~IN0;
            default: result = '0;
        endcase
    end

    // Result and flag load only on acceptance; operands of unaccepted
    // cycles never reach state.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            OUT_VALID <= 1'b0;
            OUT0      <= '0;
            EQ        <= 1'b0;
        end else begin
            if (accept) begin
                OUT_VALID <= 1'b1;
                OUT0      <= result;
                EQ        <= operands_equal;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end
        end
    end

    // Clear beats increment; increment stops at all-ones.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            MATCH_CNT <= '0;
        end else if (CLR_CNT) begin
            MATCH_CNT <= '0;
        end else if (accept && operands_equal && (MATCH_CNT != '1)) begin
            MATCH_CNT <= MATCH_CNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb_bitwise_logic_pipe
// Self-checking bench: a WIDTH=8/CNT_WIDTH=4 instance exercised with a vector
// table plus hand-written backpressure, streaming, saturation and reset
// sequences, and a default-parameter instance exercised for WIDTH=1.
module tb_bitwise_logic_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [2:0] mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out0;
    logic       eq;
    logic       clr_cnt;
    logic [3:0] match_cnt;

    logic       w1_valid;
    logic       w1_in_ready;
    logic       w1_in0;
    logic       w1_in1;
    logic       w1_out_valid;
    logic       w1_out0;
    logic       w1_eq;
    logic [7:0] w1_match_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] in0;
        logic [7:0] in1;
        logic [2:0] mode;
        logic [7:0] exp_out;
        logic       exp_eq;
    } vec_t;

    vec_t vecs[13];

    bitwise_logic_pipe #(.WIDTH(8), .CNT_WIDTH(4)) dut (
        .CLK       (clk),
        .RSTn      (rst_n),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .IN0       (in0),
        .IN1       (in1),
        .MODE      (mode),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .OUT0      (out0),
        .EQ        (eq),
        .CLR_CNT   (clr_cnt),
        .MATCH_CNT (match_cnt)
    );

    bitwise_logic_pipe dut_w1 (
        .CLK       (clk),
        .RSTn      (rst_n),
        .IN_VALID  (w1_valid),
        .IN_READY  (w1_in_ready),
        .IN0       (w1_in0),
        .IN1       (w1_in1),
        .MODE      (3'd0),
        .OUT_VALID (w1_out_valid),
        .OUT_READY (1'b1),
        .OUT0      (w1_out0),
        .EQ        (w1_eq),
        .CLR_CNT   (1'b0),
        .MATCH_CNT (w1_match_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the main instance's inputs for the next rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] m, input logic ordy, input logic clr);
        in_valid  = v;
        in0       = a;
        in1       = b;
        mode      = m;
        out_ready = ordy;
        clr_cnt   = clr;
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    initial begin
        logic [3:0] exp_cnt;
        logic [7:0] last_out;
        logic       last_eq;
        logic [1:0] w1_exp;

        // Mode sweep first, then a few beats with equal operands.
        vecs[0]  = '{8'hA5, 8'h0F, 3'd0, 8'h55, 1'b0};
        vecs[1]  = '{8'hA5, 8'h0F, 3'd1, 8'hAA, 1'b0};
        vecs[2]  = '{8'hA5, 8'h0F, 3'd2, 8'h05, 1'b0};
        vecs[3]  = '{8'hA5, 8'h0F, 3'd3, 8'hAF, 1'b0};
        vecs[4]  = '{8'hA5, 8'h0F, 3'd4, 8'hFA, 1'b0};
        vecs[5]  = '{8'hA5, 8'h0F, 3'd5, 8'h50, 1'b0};
        vecs[6]  = '{8'hA5, 8'h0F, 3'd6, 8'hA5, 1'b0};
        vecs[7]  = '{8'hA5, 8'h0F, 3'd7, 8'h5A, 1'b0};
        vecs[8]  = '{8'h3C, 8'h3C, 3'd0, 8'hFF, 1'b1};
        vecs[9]  = '{8'h00, 8'hFF, 3'd2, 8'h00, 1'b0};
        vecs[10] = '{8'h81, 8'h81, 3'd7, 8'h7E, 1'b1};
        vecs[11] = '{8'hF0, 8'h0F, 3'd5, 8'h00, 1'b0};
        vecs[12] = '{8'h6C, 8'h6C, 3'd4, 8'h93, 1'b1};

        w1_valid = 1'b0;
        w1_in0   = 1'b0;
        w1_in1   = 1'b0;
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        rst_n = 1'b0;

        // Reset state.
        #12;
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out0", {24'd0, out0}, 32'd0);
        checkOutput("rst_eq", {31'd0, eq}, 32'd0);
        checkOutput("rst_match_cnt", {28'd0, match_cnt}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10;
        rst_n = 1'b1;

        // Table: one beat per cycle, result one cycle later.
        exp_cnt = 4'd0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1'b1, vecs[i].in0, vecs[i].in1, vecs[i].mode, 1'b1, 1'b0);
            tick();
            if (vecs[i].exp_eq && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            checkOutput($sformatf("vec%0d_out0", i), {24'd0, out0}, {24'd0, vecs[i].exp_out});
            checkOutput($sformatf("vec%0d_eq", i), {31'd0, eq}, {31'd0, vecs[i].exp_eq});
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("vec%0d_cnt", i), {28'd0, match_cnt}, {28'd0, exp_cnt});
        end
        last_out = vecs[12].exp_out;
        last_eq  = vecs[12].exp_eq;

        // Drain with junk on unaccepted operand lines: state must not move.
        applyStimulus(1'b0, 8'h77, 8'h77, 3'd1, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("drain_out0_held", {24'd0, out0}, {24'd0, last_out});
        checkOutput("drain_eq_held", {31'd0, eq}, {31'd0, last_eq});
        checkOutput("drain_cnt_held", {28'd0, match_cnt}, {28'd0, exp_cnt});

        // Backpressure: first beat lands, second waits for OUT_READY.
        applyStimulus(1'b1, 8'h3C, 8'h3C, 3'd0, 1'b0, 1'b0);
        tick();
        exp_cnt = exp_cnt + 4'd1;
        applyStimulus(1'b1, 8'h12, 8'h34, 3'd1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("bp%0d_out0", i), {24'd0, out0}, 32'h0000_00FF);
            checkOutput($sformatf("bp%0d_eq", i), {31'd0, eq}, 32'd1);
            checkOutput($sformatf("bp%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("bp%0d_in_ready", i), {31'd0, in_ready}, 32'd0);
            checkOutput($sformatf("bp%0d_cnt", i), {28'd0, match_cnt}, {28'd0, exp_cnt});
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        checkOutput("bp_second_out0", {24'd0, out0}, 32'h0000_0026);
        checkOutput("bp_second_eq", {31'd0, eq}, 32'd0);
        checkOutput("bp_second_valid", {31'd0, out_valid}, 32'd1);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_drained_valid", {31'd0, out_valid}, 32'd0);

        // Streaming: ten beats on ten consecutive edges.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(i), 8'hF0, 3'd1, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream%0d_valid", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stream%0d_out0", i), {24'd0, out0}, {24'd0, 8'hF0 | 8'(i)});
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_drained_valid", {31'd0, out_valid}, 32'd0);

        // Counter: clear, saturate, then clear beats a matching beat.
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1);
        tick();
        checkOutput("cnt_cleared", {28'd0, match_cnt}, 32'd0);
        exp_cnt = 4'd0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i + 1), 8'(i + 1), 3'd6, 1'b1, 1'b0);
            tick();
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            checkOutput($sformatf("sat%0d_cnt", i), {28'd0, match_cnt}, {28'd0, exp_cnt});
        end
        checkOutput("sat_final", {28'd0, match_cnt}, 32'd15);
        applyStimulus(1'b1, 8'h44, 8'h44, 3'd6, 1'b1, 1'b1);
        tick();
        checkOutput("clr_priority_cnt", {28'd0, match_cnt}, 32'd0);
        checkOutput("clr_beat_out0", {24'd0, out0}, 32'h0000_0044);
        checkOutput("clr_beat_eq", {31'd0, eq}, 32'd1);

        // Reset mid-operation with a beat parked in the output register.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h11, 8'h11, 3'd6, 1'b1, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 8'hA5, 8'h00, 3'd7, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        checkOutput("pre_rst_out0", {24'd0, out0}, 32'h0000_005A);
        checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("pre_rst_cnt", {28'd0, match_cnt}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_out0", {24'd0, out0}, 32'd0);
        checkOutput("mid_rst_eq", {31'd0, eq}, 32'd0);
        checkOutput("mid_rst_cnt", {28'd0, match_cnt}, 32'd0);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b1, 8'h0F, 8'hF0, 3'd3, 1'b1, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        checkOutput("post_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("post_rst_out0", {24'd0, out0}, 32'h0000_00FF);
        checkOutput("post_rst_eq", {31'd0, eq}, 32'd0);
        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0);

        // Default WIDTH=1 build, XNOR over all operand combinations.
        for (int i = 0; i < 4; i++) begin
            w1_exp   = 2'(i);
            w1_valid = 1'b1;
            w1_in0   = w1_exp[1];
            w1_in1   = w1_exp[0];
            tick();
            checkOutput($sformatf("w1_%0d_out0", i), {31'd0, w1_out0},
                        {31'd0, (i == 0 || i == 3) ? 1'b1 : 1'b0});
            checkOutput($sformatf("w1_%0d_valid", i), {31'd0, w1_out_valid}, 32'd1);
        end
        w1_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 1: operand and result width in bits, legal range 1 or more.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: width of the match counter, legal range 1 or more.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RSTn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port IN_VALID, input, 1 bit: operand beat valid.
REQ-006 SHALL have port IN_READY, output, 1 bit: block can accept an operand beat.
REQ-007 SHALL have port IN0, input, WIDTH bits: operand A.
REQ-008 SHALL have port IN1, input, WIDTH bits: operand B.
REQ-009 SHALL have port MODE, input, 3 bits: operation select, sampled with the operands.
REQ-010 SHALL have port OUT_VALID, output, 1 bit: result beat valid.
REQ-011 SHALL have port OUT_READY, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port OUT0, output, WIDTH bits: registered result.
REQ-013 SHALL have port EQ, output, 1 bit: registered flag, set when the beat's IN0 equals its IN1.
REQ-014 SHALL have port CLR_CNT, input, 1 bit: synchronous clear of MATCH_CNT.
REQ-015 SHALL have port MATCH_CNT, output, CNT_WIDTH bits: count of accepted beats with IN0 equal to IN1.

Function
REQ-016 SHALL decode MODE as: 0 XNOR, 1 XOR, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 pass IN0, 7 bitwise NOT IN0.
- Operations are bitwise over all WIDTH bits.
REQ-017 SHALL drive IN_READY combinationally as (not OUT_VALID) or OUT_READY.
REQ-018 SHALL accept a beat on a rising edge where IN_VALID and IN_READY are both 1.
- On acceptance, OUT0 loads the MODE result and EQ loads (IN0 equals IN1) at that edge.
- Latency is 1 cycle.
REQ-019 SHALL set OUT_VALID on acceptance.
- OUT_VALID clears on a rising edge with OUT_VALID=1, OUT_READY=1 and no new acceptance.
- On a simultaneous output drain and new acceptance, OUT_VALID stays 1 and OUT0/EQ take the new beat, giving full throughput with no bubble.
REQ-020 SHALL hold OUT0 and EQ stable while OUT_VALID=1 and OUT_READY=0, whatever the input activity.
REQ-021 SHALL leave OUT0 and EQ unchanged when no beat is accepted.
REQ-022 SHALL compute EQ independently of MODE.
REQ-023 SHALL update MATCH_CNT as follows:
- Increment by 1 on each accepted beat with IN0 equal to IN1.
- Saturate at all-ones; no wrap.
REQ-024 SHALL give CLR_CNT priority over increment.
- CLR_CNT=1 forces MATCH_CNT to 0 at the edge, even if a matching beat is accepted at that edge.
REQ-025 SHALL ignore MODE, IN0 and IN1 when IN_VALID=0.
- No X propagation into state from unaccepted inputs.

Reset
REQ-026 SHALL, while RSTn=0, asynchronously force OUT_VALID=0, OUT0=0, EQ=0 and MATCH_CNT=0.
REQ-027 SHALL drive IN_READY=1 during reset, since it is derived from OUT_VALID=0.
REQ-028 SHALL discard any beat held in the output register when RSTn asserts mid-operation.
REQ-029 SHALL resume with the first acceptance on the first rising edge after RSTn deasserts.

Verification (WIDTH=8, CNT_WIDTH=4)
REQ-030 SHALL cover mode sweep:
- Stimulus: IN0=0xA5, IN1=0x0F, MODE 0..7, OUT_READY=1.
- Response: OUT0 = 0x55, 0xAA, 0x05, 0xAF, 0xFA, 0x50, 0xA5, 0x5A, each one cycle after its beat; EQ=0 for all.
REQ-031 SHALL cover backpressure:
- Stimulus: OUT_READY=0, beat IN0=IN1=0x3C MODE=0, then a second beat.
- Response: OUT0=0xFF, EQ=1 and OUT_VALID=1 held; IN_READY=0; second beat not accepted until OUT_READY=1.
REQ-032 SHALL cover streaming:
- Stimulus: IN_VALID=1 and OUT_READY=1 for 10 consecutive cycles.
- Response: 10 results on 10 consecutive cycles, no bubble.
REQ-033 SHALL cover counter saturation and clear:
- Stimulus: 20 accepted beats with IN0=IN1.
- Response: MATCH_CNT=15 and stays 15.
- Stimulus: CLR_CNT=1 together with a matching beat.
- Response: MATCH_CNT=0.
REQ-034 SHALL cover reset mid-operation:
- Stimulus: RSTn pulsed low asynchronously while OUT_VALID=1, OUT0=0x5A, MATCH_CNT=3.
- Response: immediately OUT_VALID=0, OUT0=0, EQ=0, MATCH_CNT=0, IN_READY=1.
REQ-035 SHALL cover WIDTH=1 default build:
- Stimulus: all 4 IN0/IN1 combinations with MODE=0.
- Response: OUT0 = 1, 0, 0, 1 for inputs 00, 01, 10, 11.
